// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
//   NUM_REQ     : number of requesters
//   IDX_W       : width of a requester index
//   arb_state_t : arbiter FSM state
package rr_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters and rr_arb8.
//   req     : level request per requester (bit i = requester i)
//   done    : current grantee finished
//   gnt_idx : registered grantee index
//   gnt_en  : registered grant-active flag
//   gnt     : one-hot grant bus
//   busy    : arbiter is in GRANT
// master = requester side, slave = arbiter side.
interface rr_arb8_if;
  import rr_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_en;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;

  modport master (output req, done, input gnt_idx, gnt_en, gnt, busy);
  modport slave  (input req, done, output gnt_idx, gnt_en, gnt, busy);
endinterface

// File: rtl/decode24.sv
// 3-to-8 enable decoder: y is one-hot at position x when en is high,
// all zero otherwise.
//   x  : index in
//   en : enable
//   y  : one-hot out
module decode24 #(
  parameter int NUM_LANES = 8,
  parameter int IDX_W     = 3
) (
  input  logic [IDX_W-1:0]     x,
  input  logic                 en,
  output logic [NUM_LANES-1:0] y
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign y[i] = en && (x == IDX_W'(i));
  end
endmodule

// File: rtl/rr_pick8.sv
// Round-robin pick: first set bit of req scanning ptr, ptr+1, ... mod 8.
//   req : request vector
//   ptr : highest-priority index
//   win : winning index (meaningful only when any is high)
//   any : at least one request present
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               any
);
  logic [2*NUM_REQ-1:0] dbl_sh;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // Rotate so bit 0 of rot is requester ptr; the wrap comes from doubling.
  assign dbl_sh = {req, req} >> ptr;
  assign rot    = dbl_sh[NUM_REQ-1:0];

  // Lowest set bit of the rotated vector is the winner's offset from ptr.
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = IDX_W'(k);
  end

  assign win = ptr + off;  // mod-8 wrap from the 3-bit width
  assign any = |req;
endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter. Holds a grant until done, the
// grantee's request drops, or HOLD_MAX cycles elapse; then rotates
// priority to the slot after the grantee. One IDLE cycle always separates
// consecutive grants. All outputs come from registers (gnt via decoder).
//   clk, rst_n : clock, async active-low reset
//   bus        : rr_arb8_if.slave (req, done in; gnt_idx, gnt_en, gnt, busy out)
//   HOLD_MAX   : max grant length in cycles, 1..255
module rr_arb8
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  rr_arb8_if.slave bus
);
  localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, idx, win;
  logic [CNT_W-1:0] cnt;
  logic             any, rel, gnt_en;

  rr_pick8 u_pick (.req(bus.req), .ptr(ptr), .win(win), .any(any));

  // Release reasons may coincide; they all lead to the same single release.
  assign rel = bus.done || !bus.req[idx] || (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = GRANT;
      GRANT:   if (rel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grant is active exactly while in GRANT, so gnt_en is a
  // straight decode of the state register.
  always_comb begin
    gnt_en = (state == GRANT);
  end

  // Datapath: grantee index, rotation pointer, hold counter.
  // idx is left untouched on release so gnt_idx shows the last grantee.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          idx <= win;
          cnt <= '0;
        end
        GRANT: if (rel) begin
          ptr <= idx + 1'b1;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end

  decode24 #(.NUM_LANES(NUM_REQ), .IDX_W(IDX_W)) u_dec (
    .x (idx),
    .en(gnt_en),
    .y (bus.gnt)
  );

  assign bus.gnt_idx = idx;
  assign bus.gnt_en  = gnt_en;
  assign bus.busy    = gnt_en;
endmodule

// File: doc/rr_arb8.md
# rr_arb8

Eight-requester round-robin arbiter that owns the one-hot select bus of a shared resource. It chooses one requester at a time and holds the grant until that requester finishes, drops its request, or reaches a hold-time limit. It then rotates priority so that no requester starves. It drives its registered 3-bit winner index and enable into the team's 3-to-8 enable decoder (`decode24`) to produce the one-hot grant bus.

## Interface

- `HOLD_MAX`, default 16: maximum cycles a grant may be held before forced release; legal range 1..255.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req` input, 8 bits: level request per requester; bit i is requester i.
- `done` input, 1 bit: the current grantee finished; sampled only in GRANT.
- `gnt_idx` output, 3 bits: registered index of the current grantee.
- `gnt_en` output, 1 bit: registered; high while a grant is active.
- `gnt` output, 8 bits: one-hot grant, equal to `decode(gnt_idx, gnt_en)`; all zero when `gnt_en` is 0.
- `busy` output, 1 bit: high when state is GRANT; equals `gnt_en`.

## Operation

- State machine has two states, IDLE and GRANT. Internal registers:
  - `ptr`, 3 bits: highest-priority index.
  - `cnt`: hold counter, width `$clog2(HOLD_MAX+1)`.
- **Reset** (`rst_n` low, takes effect immediately and asynchronously):
  - state = IDLE
  - `ptr` = 0, `cnt` = 0
  - `gnt_idx` = 0, `gnt_en` = 0, `gnt` = 8'h00, `busy` = 0
- **IDLE**:
  - If `req == 0`, stay in IDLE.
  - Otherwise, the winner is the first set bit scanning `ptr`, `ptr+1`, … mod 8.
  - On the edge: `gnt_idx` ← winner, `gnt_en` ← 1, `cnt` ← 0, state ← GRANT.
- **GRANT**: the release condition is any of:
  - `done == 1`
  - `req[gnt_idx] == 0`
  - `cnt == HOLD_MAX-1`
- When release is true:
  - On the edge: `gnt_en` ← 0, `ptr` ← `gnt_idx + 1` (mod 8, wraps 7→0), `cnt` ← 0, state ← IDLE.
  - `gnt_idx` keeps its value.
- When release is false: `cnt` ← `cnt + 1`.
- Simultaneous events:
  - Several release conditions in the same cycle produce one release with the same result.
  - `done` sampled in IDLE is ignored.
  - Changes on `req` during GRANT affect only `req[gnt_idx]`.
- Forced release: a requester that holds `req` high past `HOLD_MAX` loses the grant. It may win again only after rotation reaches it again. If it is the sole requester, it wins again after one IDLE cycle.
- `HOLD_MAX == 1`: every grant lasts exactly one cycle.

## Timing

- Request to grant: 1 cycle. A `req` seen in IDLE at edge N gives `gnt_en` = 1 after edge N.
- Grant duration: from 1 to `HOLD_MAX` cycles.
- Release to re-arbitration: there is always exactly one IDLE cycle (`gnt` = 0) between consecutive grants. Back-to-back grants are not supported.
- `gnt` is combinational only from `gnt_idx`/`gnt_en` registers, so it is glitch-free relative to `req`.
- No combinational path exists from any input to any output.

## Structure

- Package `rr_arb_pkg` contains:
  - `localparam NUM_REQ = 8`, `IDX_W = 3`
  - `typedef enum logic {IDLE, GRANT} arb_state_t`
- Sub-modules:
  - `decode24` instance: `x` = `gnt_idx`, `en` = `gnt_en`, `y` = `gnt`.
  - `rr_pick8`: combinational function or sub-module (`req`, `ptr` → winner index, `any`), a rotate-then-priority-encode. It is the only other natural split.

## Test plan

- Reset: assert `rst_n` = 0 asynchronously in the middle of a grant → `gnt` = 8'h00 and `busy` = 0 before the next clock edge. After release, `req` = 8'h01 → grant index 0.
- Single request: `req` = 8'h08 from IDLE → after 1 edge `gnt_idx` = 3, `gnt` = 8'h08. Pulse `done` → `gnt` = 8'h00 on the next edge, then `ptr` = 4.
- Full rotation: `req` = 8'hFF, pulse `done` on the first GRANT cycle of every grant → grant order 0,1,2,…,7,0, with one zero cycle between grants.
- Wrap-around priority: after a grant to 5 (`ptr` = 6), set `req` = 8'h41 → grant 6 first, then 0.
- Hold timeout: `HOLD_MAX` = 16, `req` = 8'h20 held, `done` = 0 → `gnt` = 8'h20 for exactly 16 cycles, 1 cycle of 8'h00, then 8'h20 again.
- Request drop: grantee 2 deasserts `req[2]` in its third GRANT cycle while `req[7]` is high → release on that edge, then grant 7 after one IDLE cycle.
